// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        F_IDLE  = 2'b00,
        F_REQ   = 2'b01,
        F_DRAIN = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, word} pairs with flush; head is read straight
// from registered storage.
module fetch_fifo #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_word,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_word,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] word_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    assign head_pc   = pc_mem[rd_ptr];
    assign head_word = word_mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                word_mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= push_pc;
                word_mem[wr_ptr] <= push_word;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues credit-limited reads to RAM, buffers words with their PCs,
// and hands them downstream; a redirect flushes and restarts fetch.
//   state   | meaning
//   F_IDLE  | no request outstanding
//   F_REQ   | read outstanding, result will be pushed
//   F_DRAIN | read outstanding after a redirect, result will be dropped
module instruction_fetch_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_enable,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instruction_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] PC_out
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    count_after_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign mem_read_write = 1'b1;
    assign PC_out         = pc;
    assign instr_valid    = !fifo_empty;
    assign pc_next        = pc + ADDR_W'(1);

    // Redirect outranks both sides of the FIFO.
    assign pop  = instr_valid && instr_ready && !redirect_valid;
    assign push = (state == F_REQ) && mem_ready && !redirect_valid;

    // Occupancy right after this edge's push/pop, with no request outstanding.
    assign count_after_push = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= F_IDLE;
            pc          <= '0;
            mem_enable  <= 1'b0;
            mem_address <= '0;
        end else begin
            case (state)
                F_IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (fetch_enable && !fifo_full) begin
                        state       <= F_REQ;
                        mem_enable  <= 1'b1;
                        mem_address <= pc;
                    end
                end
                F_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (mem_ready) begin
                            state      <= F_IDLE;
                            mem_enable <= 1'b0;
                        end else begin
                            state <= F_DRAIN;
                        end
                    end else if (mem_ready) begin
                        pc <= pc_next;
                        if (fetch_enable && (count_after_push < (CNT_W+1)'(DEPTH))) begin
                            mem_address <= pc_next;
                        end else begin
                            state      <= F_IDLE;
                            mem_enable <= 1'b0;
                        end
                    end
                end
                F_DRAIN: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (mem_ready) begin
                        state      <= F_IDLE;
                        mem_enable <= 1'b0;
                    end
                end
                default: begin
                    state      <= F_IDLE;
                    mem_enable <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_pc   (mem_address),
        .push_word (mem_data_out),
        .head_pc   (instr_pc),
        .head_word (instruction_out),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
